// File: rtl/bit32_mul.sv
// bit32_mul: sequential unsigned 32x8 multiplier producing an exact 40-bit product.
// A shift-add datapath retires one bit of B per clock. Every operation takes
// exactly eight iterations, even when B is zero, so the latency never varies.
// Result is registered and only changes when a product completes or on reset.
module bit32_mul (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [7:0]  B,
   output logic        busy,
   output logic        done,
   output logic [39:0] Result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [39:0] acc;
   logic [39:0] a_shift;
   logic [7:0]  b_shift;
   logic [2:0]  count;
   logic [39:0] acc_next;
   logic        accept;

   // Accumulator value after the current iteration: add the shifted A when the multiplier LSB is set
   always_comb begin
      acc_next = acc;
      if (b_shift[0]) begin
         acc_next = acc + a_shift;
      end
   end

   // A new operation is taken from IDLE, or straight from DONE for back-to-back use; start during RUN is ignored
   always_comb begin
      accept = start && ((state == IDLE) || (state == DONE));
   end

   // Control state, shift-add datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= 40'd0;
         a_shift <= 40'd0;
         b_shift <= 8'd0;
         count   <= 3'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         Result  <= 40'd0;
      end else if (accept) begin
         state   <= RUN;
         acc     <= 40'd0;
         a_shift <= {8'd0, A};
         b_shift <= B;
         count   <= 3'd0;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
            RUN: begin
               acc     <= acc_next;
               a_shift <= {a_shift[38:0], 1'b0};
               b_shift <= {1'b0, b_shift[7:1]};
               count   <= count + 3'd1;
               if (count == 3'd7) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  Result <= acc_next;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit32_mul.sv
// tb_bit32_mul: randomized and directed checks of bit32_mul against a plain
// arithmetic product model, including handshake, hold and mid-operation reset.
module tb_bit32_mul;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] A;
   logic [7:0]  B;
   logic        busy;
   logic        done;
   logic [39:0] Result;

   int passCount;
   int totalCount;

   bit32_mul dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .Result (Result)
   );

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global bound so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: exact unsigned product of the operands
   function automatic logic [39:0] refProduct(input logic [31:0] a, input logic [7:0] b);
      logic [39:0] wa;
      logic [39:0] wb;
      wa = {8'd0, a};
      wb = {32'd0, b};
      return wa * wb;
   endfunction

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
      totalCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present operands with start high; called at a falling edge
   task automatic applyStimulus(input logic [31:0] a, input logic [7:0] b);
      A     = a;
      B     = b;
      start = 1'b1;
   endtask

   // Let the accepting edge pass, drop start, then wait (bounded) for done and check latency and product
   task automatic waitDone(input string tag, input logic [39:0] expected);
      int n;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      checkOutput({tag, "_busy"}, {39'd0, busy}, 40'd1);
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checkOutput({tag, "_timeout"}, 40'd0, 40'd1);
      end else begin
         checkOutput({tag, "_latency"}, n, 40'd9);
         checkOutput({tag, "_result"}, Result, expected);
         checkOutput({tag, "_busy_done"}, {39'd0, busy}, 40'd0);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [7:0]  rb;
      passCount  = 0;
      totalCount = 0;
      rst_n = 1'b0;
      start = 1'b0;
      A     = 32'd0;
      B     = 8'd0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_result", Result, 40'd0);
      checkOutput("reset_busy", {39'd0, busy}, 40'd0);
      checkOutput("reset_done", {39'd0, done}, 40'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed products
      applyStimulus(32'd0, 8'd0);
      waitDone("zero", refProduct(32'd0, 8'd0));
      @(negedge clk);
      checkOutput("done_pulse", {39'd0, done}, 40'd0);
      applyStimulus(32'd5, 8'd6);
      waitDone("5x6", 40'h1E);
      @(negedge clk);
      applyStimulus(32'd30, 8'd10);
      waitDone("30x10", 40'h12C);
      @(negedge clk);
      applyStimulus(32'hFFFF_FFFF, 8'hFF);
      waitDone("max", 40'hFE_FFFF_FF01);
      @(negedge clk);
      applyStimulus(32'hFFFF_FFFF, 8'h7F);
      waitDone("max7f", 40'h7E_FFFF_FF81);
      @(negedge clk);

      // Start during RUN with different operands must be ignored
      applyStimulus(32'd5, 8'd6);
      @(negedge clk);
      A = 32'd7;
      B = 8'd7;
      repeat (4) @(negedge clk);
      start = 1'b0;
      begin
         int n;
         n = 5;
         while (!done && n < 20) begin
            @(negedge clk);
            n++;
         end
         checkOutput("ignore_latency", n, 40'd9);
         checkOutput("ignore_result", Result, 40'h1E);
      end

      // Back-to-back: start held at the DONE edge
      applyStimulus(32'd3, 8'd4);
      waitDone("b2b", 40'd12);
      @(negedge clk);

      // Hold: Result and done stay put while inputs wander with start low
      applyStimulus(32'd30, 8'd10);
      waitDone("hold_op", 40'd300);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         A = $urandom;
         B = 8'($urandom);
         checkOutput("hold_result", Result, 40'd300);
         checkOutput("hold_done", {39'd0, done}, 40'd0);
      end

      // Reset in the middle of an operation
      applyStimulus(32'd30, 8'd10);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_result", Result, 40'd0);
      checkOutput("midrst_busy", {39'd0, busy}, 40'd0);
      checkOutput("midrst_done", {39'd0, done}, 40'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
         end
         checkOutput("midrst_no_done", seen, 40'd0);
      end
      applyStimulus(32'd123456, 8'd200);
      waitDone("after_rst", refProduct(32'd123456, 8'd200));
      @(negedge clk);

      // Randomized operands, some issued back-to-back
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = 8'($urandom);
         applyStimulus(ra, rb);
         waitDone("rand", refProduct(ra, rb));
         if ($urandom_range(0, 1) == 0) begin
            @(negedge clk);
            checkOutput("rand_pulse", {39'd0, done}, 40'd0);
         end
      end
      @(negedge clk);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/bit32_mul.md
# bit32_mul

Sequential unsigned multiplier: 32-bit operand A times 8-bit operand B gives an exact 40-bit product. It uses a shift-add datapath that retires one bit of B per clock, with a start/done handshake. It is the narrow-by-wide scaling multiplier for datapaths that cannot afford a full combinational 32x8 array. The output register holds the last product until the next operation completes.

## Interface
- No parameters. Widths are fixed: A is 32 bits, B is 8 bits, Result is 40 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled on the rising edge.
- A  input  32  unsigned multiplicand; captured when start is accepted.
- B  input  8  unsigned multiplier; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; Result is valid and newly updated.
- Result  output  40  unsigned product A*B; registered and held.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 3-bit iteration counter.
  - DONE: a one-cycle state in which done=1 and busy=0.
- Transitions:
  - IDLE→RUN when start=1 at an edge. Both operands are latched: A zero-extended to 40 bits, B into an 8-bit shift register. The internal accumulator clears to 0 and the counter clears to 0.
  - In RUN, each edge: if the LSB of the B shift register is 1, the accumulator gains the shifted A. Shifted A shifts left by 1 and the B register shifts right by 1. The counter increments.
  - After the 8th iteration, go to DONE and load Result with the final accumulator value.
  - DONE→IDLE on the next edge. If start=1 at that edge, go directly to RUN with new operands (back-to-back).
- Start while in RUN is ignored. The operands in flight are unaffected.
- Changes to A/B after acceptance have no effect on the operation in flight.
- Arithmetic: unsigned only. Result = A*B exactly. The maximum is 0xFE_FFFF_FF01, which fits 40 bits, so overflow is impossible.
- Early termination is not permitted: latency is fixed regardless of B (including B=0).
- Result changes only on entry to DONE or on reset.

## Timing
- Reset (asserting rst_n low at any time, including mid-RUN):
  - Immediately: busy=0, done=0, Result=0, state=IDLE.
  - Accumulator and counter clear. Any in-flight operation is abandoned.
- Deasserting rst_n is sampled synchronously; the first start is accepted at the first rising edge after release.
- Latency: start accepted at edge k → 8 iterations at edges k+1..k+8 → Result valid and done=1 after edge k+8, for exactly one cycle.
- busy is high after edge k through edge k+8, and low in the DONE cycle.
- Throughput: one operation per 9 cycles back-to-back (start held high at the DONE edge).
- done never asserts without a preceding accepted start.

## Test plan
- Reset and zero operands:
  - Reset asserted → Result=0, busy=0, done=0.
  - Start with A=0, B=0 → done after 8+1 edges, Result=0.
- Small values:
  - A=5, B=6 → Result=30 (0x1E).
  - A=30, B=10 → Result=300 (0x12C).
- Extremes:
  - A=0xFFFF_FFFF, B=0xFF → Result=0xFE_FFFF_FF01.
  - A=0xFFFF_FFFF, B=0x7F → Result=0x7E_FFFF_FF81.
- Handshake:
  - Pulse start with A=5, B=6. Then drive start=1 with A=7, B=7 during RUN → ignored; Result=30.
  - Back-to-back start held at the DONE edge with A=3, B=4 → next done gives Result=12, 9 cycles after the first done.
- Reset mid-operation:
  - Assert rst_n low at iteration 4 of A=30, B=10 → Result=0 and busy=0 immediately; no done follows.
  - A new start after release yields the correct product.
- Hold: after done with Result=300, change A/B with start=0 for 20 cycles → Result stays 300 and done stays 0.
